tcp_mac_filter_axis: RTL and testbench
======================================

// Module: tcp_mac_filter_axis
// PURPOSE
//  Parametrised successor to the single-address network input filter. Sits between the 10G MAC Rx
//  stream and the input FIFO; forwards whole frames whose destination MAC matches any enabled
//  table entry, or broadcast, and silently drops all others.
//  Provides a registered, skid-buffered AXIS path, selectable bus width and per-filter statistics.
// PARAMETERS
//  DATA_W   64   stream data width, bits; multiple of 64, >= 64
//  N_ADDR   4    number of MAC address table entries, 1..16
//  CNT_W    32   width of pass/drop statistics counters
// PORTS
//  Clock         in   1            sole clock, all logic rising-edge
//  Reset         in   1            asynchronous, active-low reset
//  InTData       in   DATA_W       Rx data; byte 0 = first wire byte, in [7:0]
//  InTKeep       in   DATA_W/8     byte enables
//  InTLast       in   1            last beat of frame
//  InTValid      in   1            input beat valid
//  InTReady      out  1            input beat accepted when InTValid & InTReady
//  OutTData      out  DATA_W       filtered data
//  OutTKeep      out  DATA_W/8     filtered byte enables
//  OutTLast      out  1            filtered last
//  OutTValid     out  1            output valid
//  OutTReady     in   1            downstream ready
//  OurMacAddr    in   48*N_ADDR    table; entry i = [48*i+47:48*i], wire byte 0 at [47:40]
//  AddrEnable    in   N_ADDR       per-entry enable
//  PromiscEn     in   1            accept every frame
//  CntClear      in   1            synchronous clear of statistics counters
//  PassCnt       out  CNT_W        frames forwarded
//  DropCnt       out  CNT_W        frames dropped
// BEHAVIOUR
//  - Reset (async, Reset=0): FSM=SOF, skid empty, OutTValid=0, OutTData/Keep/Last=0, InTReady=0
//    while asserted, 1 from first Clock after release; PassCnt=DropCnt=0.
//  - DestMac = {b0,b1,b2,b3,b4,b5} from first beat; b0 = InTData[7:0]. Match = PromiscEn |
//    (DestMac==48'hFFFF_FFFF_FFFF) | OR_i(AddrEnable[i] & DestMac==entry i). Combinational on beat 0.
//  - FSM: SOF --beat accepted, match, !InTLast--> PASS; SOF --no match, !InTLast--> DROP;
//    PASS/DROP --beat accepted with InTLast--> SOF. Single-beat frame returns to SOF directly.
//  - Runt: first beat with InTLast and InTKeep[5:0]!=6'h3F -> dropped regardless of match.
//  - Decision made once per frame; AddrEnable/table/PromiscEn changes mid-frame do not affect it.
//  - Datapath: 2-entry skid buffer. InTReady = (skid not full) in SOF/PASS; InTReady=1 in DROP
//    (dropped beats consume no storage). Latency: accepted beat appears on Out* next cycle when
//    skid empty and OutTReady=1. Full throughput, one beat/cycle, no bubbles at sustained ready.
//  - AXIS rules: OutTValid never deasserts and Out* never change until OutTReady; data order kept.
//  - Counters: PassCnt +1 on SOF decision to pass, DropCnt +1 on SOF decision to drop (counted at
//    first beat). Saturate at all-ones, no wrap. CntClear same cycle as increment: clear wins, 0.
//  - Reset mid-frame: frame in flight discarded; next accepted beat treated as start of frame.
// CONFIGURATION
//  TCP_FILTER_MCAST_EN defined: additionally accept multicast (b0[0]==1), added to Match term,
//    and MCastCnt out CNT_W counts accepted multicast frames (excluding broadcast); same
//    saturate/clear rules.
//  Not defined: multicast frames pass only via PromiscEn or exact table hit; MCastCnt port absent.
// TESTING
//  1 Entry0=02:00:00:00:00:01 enabled, 3-beat frame to that MAC -> 3 beats out, same data/keep,
//    OutTLast on beat 3, PassCnt=1, first beat out 1 cycle after accept.
//  2 Frame to 02:00:00:00:00:99, entry disabled, PromiscEn=0 -> no Out beats, InTReady=1
//    throughout, DropCnt=1; following matching frame forwarded intact.
//  3 Broadcast FF:FF:FF:FF:FF:FF, 1-beat, InTKeep=8'hFF -> forwarded; 1-beat with InTKeep=8'h0F
//    -> dropped as runt, DropCnt increments.
//  4 OutTReady random 50% over 20 back-to-back matching frames -> no loss/dup/reorder, InTReady
//    low only when skid holds 2 beats, OutT* stable while stalled.
//  5 PassCnt preloaded via CNT_W=4 and 16 passes -> holds 4'hF; CntClear with pass same cycle -> 0.
//  6 Reset=0 asserted mid-frame for 2 cycles -> OutTValid=0 immediately, counters 0, next frame's
//    first beat filtered correctly.

Source files
------------

// File: rtl/tcp_mac_filter_axis.sv
// Destination-MAC frame filter between the 10G MAC Rx stream and the input FIFO, with a 2-entry skid buffer and pass/drop counters.
// Optional build macro TCP_FILTER_MCAST_EN: also accept multicast frames and expose the MCastCnt counter.
module tcp_mac_filter_axis #(
  parameter int DATA_W = 64,
  parameter int N_ADDR = 4,
  parameter int CNT_W  = 32
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [DATA_W-1:0]   InTData,
  input  logic [DATA_W/8-1:0] InTKeep,
  input  logic                InTLast,
  input  logic                InTValid,
  output logic                InTReady,
  output logic [DATA_W-1:0]   OutTData,
  output logic [DATA_W/8-1:0] OutTKeep,
  output logic                OutTLast,
  output logic                OutTValid,
  input  logic                OutTReady,
  input  logic [48*N_ADDR-1:0] OurMacAddr,
  input  logic [N_ADDR-1:0]   AddrEnable,
  input  logic                PromiscEn,
  input  logic                CntClear,
  output logic [CNT_W-1:0]    PassCnt,
  output logic [CNT_W-1:0]    DropCnt
`ifdef TCP_FILTER_MCAST_EN
  ,
  output logic [CNT_W-1:0]    MCastCnt
`endif
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int BEAT_W = DATA_W + KEEP_W + 1;

  typedef enum logic [1:0] {SOF, PASS, DROP} state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   out_q, out_d;
  logic [BEAT_W-1:0]   skid_q, skid_d;
  logic [1:0]          count_q, count_d;
  logic                rdy_q;
  logic [CNT_W-1:0]    pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

  logic [47:0]         dest_mac;
  logic                table_hit, is_bcast, match, runt, pass_dec;
  logic                in_fire, sof_fire, push, pop;
  logic [BEAT_W-1:0]   in_beat;

  // Wire byte 0 sits in the low data byte but is the most significant MAC byte.
  always_comb begin
    dest_mac = '0;
    for (int k = 0; k < 6; k++) begin
      dest_mac[47-8*k -: 8] = InTData[8*k +: 8];
    end
  end

  always_comb begin
    table_hit = 1'b0;
    for (int i = 0; i < N_ADDR; i++) begin
      if (AddrEnable[i] && (OurMacAddr[48*i +: 48] == dest_mac)) begin
        table_hit = 1'b1;
      end
    end
  end

  assign is_bcast = (dest_mac == 48'hFFFF_FFFF_FFFF);
`ifdef TCP_FILTER_MCAST_EN
  logic is_mcast;
  assign is_mcast = dest_mac[40];
  assign match    = PromiscEn | is_bcast | table_hit | is_mcast;
`else
  assign match    = PromiscEn | is_bcast | table_hit;
`endif
  assign runt     = InTLast & (InTKeep[5:0] != 6'h3F);
  assign pass_dec = match & ~runt;

  // Dropped beats bypass storage, so DROP never back-pressures.
  assign InTReady = rdy_q & ((state_q == DROP) | (count_q != 2'd2));
  assign in_fire  = InTValid & InTReady;
  assign sof_fire = in_fire & (state_q == SOF);
  assign push     = in_fire & (((state_q == SOF) & pass_dec) | (state_q == PASS));
  assign pop      = (count_q != 2'd0) & OutTReady;
  assign in_beat  = {InTLast, InTKeep, InTData};

  always_comb begin
    state_d = state_q;
    if (in_fire) begin
      unique case (state_q)
        SOF:        if (!InTLast) state_d = pass_dec ? PASS : DROP;
        PASS, DROP: if (InTLast)  state_d = SOF;
        default:    state_d = SOF;
      endcase
    end
  end

  // out_q is the head of the 2-entry buffer and drives Out* directly.
  always_comb begin
    out_d   = out_q;
    skid_d  = skid_q;
    count_d = count_q;
    unique case (count_q)
      2'd0: if (push) begin
        out_d   = in_beat;
        count_d = 2'd1;
      end
      2'd1: begin
        if (push && pop) begin
          out_d = in_beat;
        end else if (push) begin
          skid_d  = in_beat;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: if (pop) begin
        out_d   = skid_q;
        count_d = 2'd1;
      end
      default: count_d = 2'd0;
    endcase
  end

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (CntClear) begin
      pass_cnt_d = '0;
      drop_cnt_d = '0;
    end else if (sof_fire) begin
      if (pass_dec && (pass_cnt_q != '1)) pass_cnt_d = pass_cnt_q + CNT_W'(1);
      if (!pass_dec && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= SOF;
      out_q      <= '0;
      skid_q     <= '0;
      count_q    <= 2'd0;
      rdy_q      <= 1'b0;
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      count_q    <= count_d;
      rdy_q      <= 1'b1;
      pass_cnt_q <= pass_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef TCP_FILTER_MCAST_EN
  logic [CNT_W-1:0] mcast_cnt_q, mcast_cnt_d;

  always_comb begin
    mcast_cnt_d = mcast_cnt_q;
    if (CntClear) begin
      mcast_cnt_d = '0;
    end else if (sof_fire && pass_dec && is_mcast && !is_bcast && (mcast_cnt_q != '1)) begin
      mcast_cnt_d = mcast_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) mcast_cnt_q <= '0;
    else        mcast_cnt_q <= mcast_cnt_d;
  end

  assign MCastCnt = mcast_cnt_q;
`endif

  assign OutTValid = (count_q != 2'd0);
  assign OutTData  = out_q[DATA_W-1:0];
  assign OutTKeep  = out_q[DATA_W +: KEEP_W];
  assign OutTLast  = out_q[BEAT_W-1];
  assign PassCnt   = pass_cnt_q;
  assign DropCnt   = drop_cnt_q;

endmodule

// File: tb/tb_tcp_mac_filter_axis.sv
// Directed testbench for tcp_mac_filter_axis: scoreboard of forwarded beats, counter and handshake checks.
module tb_tcp_mac_filter_axis;

  localparam int DATA_W = 64;
  localparam int N_ADDR = 4;
  localparam int CNT_W  = 4;
  localparam logic [47:0] MAC_E0    = 48'h02_00_00_00_00_01;
  localparam logic [47:0] MAC_E1    = 48'h02_00_00_00_00_99;
  localparam logic [47:0] MAC_BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MAC_MCAST = 48'h01_00_5E_00_00_01;
  localparam logic [47:0] MAC_OTHER = 48'h02_AA_BB_CC_DD_EE;

  logic                Clock = 1'b0;
  logic                Reset = 1'b0;
  logic [DATA_W-1:0]   InTData = '0;
  logic [DATA_W/8-1:0] InTKeep = '0;
  logic                InTLast = 1'b0;
  logic                InTValid = 1'b0;
  logic                InTReady;
  logic [DATA_W-1:0]   OutTData;
  logic [DATA_W/8-1:0] OutTKeep;
  logic                OutTLast;
  logic                OutTValid;
  logic                OutTReady = 1'b1;
  logic [48*N_ADDR-1:0] OurMacAddr = '0;
  logic [N_ADDR-1:0]   AddrEnable = '0;
  logic                PromiscEn = 1'b0;
  logic                CntClear = 1'b0;
  logic [CNT_W-1:0]    PassCnt;
  logic [CNT_W-1:0]    DropCnt;

  int compared   = 0;
  int mismatched = 0;
  logic [72:0] sbq[$];
  bit  randMode = 0;
  bit  readyCheck = 0;
  bit  expectReadyHigh = 0;
  int  occ = 0;
  bit  holdPending = 0;
  logic [73:0] heldVec = '0;

  tcp_mac_filter_axis #(.DATA_W(DATA_W), .N_ADDR(N_ADDR), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset),
    .InTData(InTData), .InTKeep(InTKeep), .InTLast(InTLast), .InTValid(InTValid), .InTReady(InTReady),
    .OutTData(OutTData), .OutTKeep(OutTKeep), .OutTLast(OutTLast), .OutTValid(OutTValid), .OutTReady(OutTReady),
    .OurMacAddr(OurMacAddr), .AddrEnable(AddrEnable), .PromiscEn(PromiscEn), .CntClear(CntClear),
    .PassCnt(PassCnt), .DropCnt(DropCnt)
  );

  always #5 Clock = ~Clock;

  // Downstream ready is either always-on or a coin toss per cycle
  always @(posedge Clock) begin
    #1;
    OutTReady = randMode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] mkBeat0(input logic [47:0] mac, input logic [15:0] hi);
    logic [63:0] d;
    d = '0;
    for (int k = 0; k < 6; k++) d[8*k +: 8] = mac[47-8*k -: 8];
    d[63:48] = hi;
    return d;
  endfunction

  // Monitor: scoreboard pops, stall stability, and ready-vs-occupancy tracking
  always @(negedge Clock) begin
    if (!Reset) begin
      holdPending = 0;
    end else begin
      if (holdPending)
        checkOutput("stall_stable", {OutTValid, OutTLast, OutTKeep, OutTData}, heldVec);
      if (OutTValid && !OutTReady) begin
        holdPending = 1;
        heldVec = {OutTValid, OutTLast, OutTKeep, OutTData};
      end else begin
        holdPending = 0;
      end
      if (OutTValid && OutTReady) begin
        if (sbq.size() == 0) checkOutput("unexpected_beat", 1, 0);
        else checkOutput("beat", {OutTLast, OutTKeep, OutTData}, sbq.pop_front());
      end
      if (expectReadyHigh) checkOutput("drop_ready", InTReady, 1);
      if (readyCheck) begin
        checkOutput("ready_vs_occ", InTReady, (occ != 2));
        occ = occ + ((InTValid && InTReady) ? 1 : 0) - ((OutTValid && OutTReady) ? 1 : 0);
      end
    end
  end

  // Present one beat (called just after a rising edge), returns just after the edge that took it
  task automatic sendBeat(input logic [63:0] data, input logic [7:0] keep, input logic last);
    bit accepted;
    InTData = data; InTKeep = keep; InTLast = last; InTValid = 1'b1;
    accepted = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge Clock);
      if (InTReady) begin accepted = 1; break; end
    end
    @(posedge Clock); #1;
    checkOutput("accept_timeout", accepted, 1);
  endtask

  task automatic applyStimulus(input logic [47:0] mac, input int nBeats, input logic [7:0] lastKeep, input bit fwd);
    logic [63:0] d;
    logic [7:0]  kp;
    logic        lst;
    for (int b = 0; b < nBeats; b++) begin
      d   = (b == 0) ? mkBeat0(mac, 16'($urandom)) : {$urandom, $urandom};
      lst = (b == nBeats - 1);
      kp  = lst ? lastKeep : 8'hFF;
      if (fwd) sbq.push_back({lst, kp, d});
      sendBeat(d, kp, lst);
    end
    InTValid = 1'b0;
  endtask

  task automatic waitIdle();
    InTValid = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(negedge Clock);
      if (sbq.size() == 0 && !OutTValid) break;
    end
    checkOutput("drain", sbq.size(), 0);
    @(posedge Clock); #1;
  endtask

  task automatic clearCounters();
    CntClear = 1'b1;
    @(posedge Clock); #1;
    CntClear = 1'b0;
  endtask

  initial begin
    logic [63:0] b0;
    OurMacAddr[47:0]  = MAC_E0;
    OurMacAddr[95:48] = MAC_E1;
    AddrEnable = 4'b0001;
    #1;
    checkOutput("rst_valid", OutTValid, 0);
    checkOutput("rst_data", {OutTLast, OutTKeep, OutTData}, 0);
    checkOutput("rst_ready", InTReady, 0);
    checkOutput("rst_cnt", {PassCnt, DropCnt}, 0);
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b1;
    #1 checkOutput("ready_before_clk", InTReady, 0);
    @(posedge Clock); #1;
    checkOutput("ready_after_clk", InTReady, 1);

    $display("[TB] test 1: 3-beat frame to entry 0");
    b0 = mkBeat0(MAC_E0, 16'h1234);
    sbq.push_back({1'b0, 8'hFF, b0});
    sendBeat(b0, 8'hFF, 1'b0);
    checkOutput("latency_valid", OutTValid, 1);
    checkOutput("latency_data", OutTData, b0);
    sbq.push_back({1'b0, 8'hFF, 64'hDEAD_BEEF_0000_0001});
    sendBeat(64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0);
    sbq.push_back({1'b1, 8'h3F, 64'hCAFE_F00D_0000_0002});
    sendBeat(64'hCAFE_F00D_0000_0002, 8'h3F, 1'b1);
    waitIdle();
    checkOutput("t1_cnt", {PassCnt, DropCnt}, {4'd1, 4'd0});

    $display("[TB] test 2: unmatched frame dropped, then matching frame");
    expectReadyHigh = 1;
    applyStimulus(MAC_E1, 3, 8'hFF, 0);
    expectReadyHigh = 0;
    applyStimulus(MAC_E0, 2, 8'hFF, 1);
    waitIdle();
    checkOutput("t2_cnt", {PassCnt, DropCnt}, {4'd2, 4'd1});

    $display("[TB] test 3: broadcast, runt, multicast, promiscuous");
    clearCounters();
    checkOutput("clear", {PassCnt, DropCnt}, 0);
    applyStimulus(MAC_BCAST, 1, 8'hFF, 1);
    applyStimulus(MAC_BCAST, 1, 8'h0F, 0);
    applyStimulus(MAC_MCAST, 1, 8'hFF, 0);
    PromiscEn = 1'b1;
    applyStimulus(MAC_OTHER, 2, 8'h07, 1);
    PromiscEn = 1'b0;
    waitIdle();
    checkOutput("t3_cnt", {PassCnt, DropCnt}, {4'd2, 4'd2});

    $display("[TB] test 4: 20 frames with random downstream ready");
    clearCounters();
    occ = 0;
    readyCheck = 1;
    randMode = 1;
    for (int i = 0; i < 20; i++)
      applyStimulus((i % 3 == 0) ? MAC_BCAST : MAC_E0, 1 + $urandom_range(0, 3), 8'hFF, 1);
    waitIdle();
    randMode = 0;
    readyCheck = 0;
    checkOutput("t4_cnt_sat", {PassCnt, DropCnt}, {4'hF, 4'd0});

    $display("[TB] test 5: saturation and clear-wins");
    clearCounters();
    for (int i = 0; i < 16; i++) applyStimulus(MAC_BCAST, 1, 8'hFF, 1);
    waitIdle();
    checkOutput("t5_sat", PassCnt, 4'hF);
    CntClear = 1'b1;
    sbq.push_back({1'b1, 8'hFF, mkBeat0(MAC_BCAST, 16'h5555)});
    sendBeat(mkBeat0(MAC_BCAST, 16'h5555), 8'hFF, 1'b1);
    CntClear = 1'b0;
    InTValid = 1'b0;
    checkOutput("t5_clear_wins", PassCnt, 4'd0);
    waitIdle();

    $display("[TB] test 6: reset mid-frame");
    b0 = mkBeat0(MAC_E0, 16'h6666);
    sbq.push_back({1'b0, 8'hFF, b0});
    sendBeat(b0, 8'hFF, 1'b0);
    checkOutput("t6_pre_pass", PassCnt, 4'd1);
    Reset = 1'b0;
    InTValid = 1'b0;
    #1;
    checkOutput("t6_rst_valid", OutTValid, 0);
    checkOutput("t6_rst_cnt", {PassCnt, DropCnt}, 0);
    checkOutput("t6_rst_ready", InTReady, 0);
    sbq.delete();
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
    applyStimulus(MAC_OTHER, 2, 8'hFF, 0);
    applyStimulus(MAC_E0, 2, 8'hFF, 1);
    waitIdle();
    checkOutput("t6_cnt", {PassCnt, DropCnt}, {4'd1, 4'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
